// File: rtl/gfx_defs_pkg.sv
// gfx_defs: shared shader-processor types and top-level instance parameters.
package gfx_defs;
  localparam int VREG_W = 6;
  localparam int DATA_W = 32;
  localparam int GFX_SP_WB_SOURCES = 2;
  typedef logic [VREG_W-1:0] vreg_num;
  typedef struct packed {
    vreg_num dst;
    logic [DATA_W-1:0] data;
  } wb_op;
endpackage

// File: rtl/gfx_rr_arbiter.sv
// gfx_rr_arbiter: combinational round-robin pick starting just after the last winner.
module gfx_rr_arbiter #(
  parameter int N = 2,
  localparam int LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  input  logic          enable,
  output logic [LW-1:0] grant,
  output logic          grant_valid
);
  logic [LW-1:0] idx;
  logic          found;
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx = '0;
    for (int k = 1; k <= N; k++) begin
      idx = LW'((int'(last) + k) % N);
      if (!found && req[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
    grant_valid = enable && found;
  end
endmodule

// File: rtl/gfx_sp_writeback.sv
// gfx_sp_writeback: round-robin merge of writeback producers into one registered
// register-file write port that can be stalled.
import gfx_defs::*;
module gfx_sp_writeback #(
  parameter int SOURCES = GFX_SP_WB_SOURCES,
  localparam int SW = (SOURCES > 1) ? $clog2(SOURCES) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  wb_op [SOURCES-1:0]   in_wb,
  input  logic [SOURCES-1:0]   in_valid,
  output logic [SOURCES-1:0]   in_ready,
  input  logic                 wr_stall,
  output logic                 wr_en,
  output vreg_num              wr_reg,
  output logic [DATA_W-1:0]    wr_data,
  output logic [SW-1:0]        wr_src
);
  logic          out_valid_q, out_valid_d;
  wb_op          out_op_q, out_op_d;
  logic [SW-1:0] out_src_q, out_src_d;
  logic [SW-1:0] last_q, last_d;
  logic [SW-1:0] grant;
  logic          load, accept;
  // Refill is allowed in the same cycle the held op drains.
  assign load = !out_valid_q || !wr_stall;
  gfx_rr_arbiter #(.N(SOURCES)) u_arb (
    .req        (in_valid),
    .last       (last_q),
    .enable     (load),
    .grant      (grant),
    .grant_valid(accept)
  );
  always_comb begin
    in_ready    = SOURCES'(accept) << grant;
    out_valid_d = accept ? 1'b1 : (wr_stall && out_valid_q);
    out_op_d    = accept ? in_wb[grant] : out_op_q;
    out_src_d   = accept ? grant : out_src_q;
    last_d      = accept ? grant : last_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      last_q      <= SW'(SOURCES - 1);
    end else begin
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
    end
  end
  always_ff @(posedge clk) begin
    out_op_q  <= out_op_d;
    out_src_q <= out_src_d;
  end
  assign wr_en   = out_valid_q && !wr_stall;
  assign wr_reg  = out_op_q.dst;
  assign wr_data = out_op_q.data;
  assign wr_src  = out_src_q;
endmodule

// File: tb/tb_gfx_sp_writeback.sv
// tb_gfx_sp_writeback: directed checks on 2- and 3-source instances plus a
// randomized run against a round-robin reference model.
import gfx_defs::*;
module tb_gfx_sp_writeback;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  wb_op [1:0]  wb2 = '0;
  logic [1:0]  v2 = '0, r2;
  logic        st2 = 1'b0, en2;
  vreg_num     reg2;
  logic [31:0] data2;
  logic        src2;
  wb_op [2:0]  wb3 = '0;
  logic [2:0]  v3 = '0, r3;
  logic        st3 = 1'b0, en3;
  vreg_num     reg3;
  logic [31:0] data3;
  logic [1:0]  src3;
  int n_cmp = 0, n_err = 0;
  gfx_sp_writeback #(.SOURCES(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_wb(wb2), .in_valid(v2), .in_ready(r2),
    .wr_stall(st2), .wr_en(en2), .wr_reg(reg2), .wr_data(data2), .wr_src(src2)
  );
  gfx_sp_writeback #(.SOURCES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .in_wb(wb3), .in_valid(v3), .in_ready(r3),
    .wr_stall(st3), .wr_en(en3), .wr_reg(reg3), .wr_data(data3), .wr_src(src3)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Producer obligation: payload must not move while offered and not taken.
  logic [1:0] hold_q = '0;
  wb_op [1:0] wb_q = '0;
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (hold_q[i] && v2[i])
        assert (wb2[i] === wb_q[i]) else $error("producer obligation broken on source %0d", i);
    hold_q <= v2 & ~r2;
    wb_q   <= wb2;
  end
  logic       m_ov;
  wb_op       m_op;
  logic       m_src;
  int         m_last, g;
  logic       m_acc, m_load;
  logic [1:0] keep;
  initial begin
    #12;
    chk("reset_wr_en2", en2, 0);
    chk("reset_wr_en3", en3, 0);
    @(negedge clk) rst_n = 1'b1;
    // single op from source 0
    @(negedge clk);
    v2 = 2'b01; wb2[0] = '{dst: 6'd3, data: 32'hDEAD_0001};
    #1 chk("single_ready", r2, 2'b01);
    @(negedge clk);
    v2 = 2'b00;
    #1 chk("single_en", en2, 1);
    chk("single_reg", reg2, 3);
    chk("single_data", data2, 32'hDEAD_0001);
    chk("single_src", src2, 0);
    @(negedge clk);
    #1 chk("single_drained", en2, 0);
    // both valid: last=0 so grants go 1,0,1,0
    wb2[0] = '{dst: 6'd5, data: 32'hAAAA};
    wb2[1] = '{dst: 6'd6, data: 32'hBBBB};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      v2 = 2'b11;
      #1 chk("rr_ready", r2, (k % 2 == 0) ? 2'b10 : 2'b01);
      if (k > 0) begin
        chk("rr_en", en2, 1);
        chk("rr_src", src2, (k % 2 == 1) ? 1 : 0);
        chk("rr_data", data2, (k % 2 == 1) ? 32'hBBBB : 32'hAAAA);
      end
    end
    @(negedge clk);
    v2 = 2'b00;
    #1 chk("rr_last_src", src2, 0);
    chk("rr_last_data", data2, 32'hAAAA);
    @(negedge clk);
    // hold an op from source 1, then stall three cycles with both valid
    v2 = 2'b10; wb2[1] = '{dst: 6'd7, data: 32'h1111};
    #1 chk("stall_load_ready", r2, 2'b10);
    @(negedge clk);
    v2 = 2'b11; st2 = 1'b1;
    wb2[0] = '{dst: 6'd9, data: 32'h2222};
    wb2[1] = '{dst: 6'd10, data: 32'h3333};
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1 chk("stall_ready", r2, 2'b00);
      chk("stall_en", en2, 0);
      chk("stall_reg", reg2, 7);
      chk("stall_data", data2, 32'h1111);
      chk("stall_src", src2, 1);
    end
    @(negedge clk);
    st2 = 1'b0;
    #1 chk("unstall_en", en2, 1);
    chk("unstall_reg", reg2, 7);
    chk("unstall_ready", r2, 2'b01);
    @(negedge clk);
    v2 = 2'b10;
    #1 chk("refill_src", src2, 0);
    chk("refill_data", data2, 32'h2222);
    chk("refill_ready", r2, 2'b10);
    @(negedge clk);
    v2 = 2'b00;
    #1 chk("refill2_src", src2, 1);
    chk("refill2_data", data2, 32'h3333);
    chk("refill2_reg", reg2, 10);
    // three sources: make last=0, then 0 and 2 valid skips source 1
    @(negedge clk);
    v3 = 3'b001; wb3[0] = '{dst: 6'd1, data: 32'h10};
    #1 chk("s3_first_ready", r3, 3'b001);
    @(negedge clk);
    v3 = 3'b101;
    wb3[0] = '{dst: 6'd2, data: 32'h20};
    wb3[2] = '{dst: 6'd4, data: 32'h40};
    #1 chk("s3_skip_ready", r3, 3'b100);
    @(negedge clk);
    #1 chk("s3_src2", src3, 2);
    chk("s3_reg2", reg3, 4);
    chk("s3_wrap_ready", r3, 3'b001);
    @(negedge clk);
    v3 = 3'b000;
    #1 chk("s3_src0", src3, 0);
    chk("s3_data0", data3, 32'h20);
    // reset while a stalled op is held
    @(negedge clk);
    v2 = 2'b01; st2 = 1'b1; wb2[0] = '{dst: 6'd12, data: 32'h5};
    #1 chk("rst_load_ready", r2, 2'b01);
    @(negedge clk);
    v2 = 2'b00;
    #1 chk("rst_held_en", en2, 0);
    chk("rst_held_reg", reg2, 12);
    #1 rst_n = 1'b0; st2 = 1'b0;
    #1 chk("rst_async_en", en2, 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1 chk("rst_no_write", en2, 0);
    v2 = 2'b11;
    #1 chk("rst_first_grant", r2, 2'b01);
    @(negedge clk);
    v2 = 2'b00;
    #1 chk("rst_first_src", src2, 0);
    @(negedge clk);
    // randomized traffic against a reference model
    m_ov = 1'b0; m_last = 0; m_op = '0; m_src = 1'b0; keep = '0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        if (!keep[i]) begin
          v2[i] = 1'($urandom_range(0, 1));
          wb2[i] = '{dst: 6'($urandom), data: $urandom};
        end
      st2 = ($urandom_range(0, 3) == 0);
      #1;
      m_load = !m_ov || !st2;
      g = -1;
      for (int k = 1; k <= 2; k++)
        if (g < 0 && v2[(m_last + k) % 2]) g = (m_last + k) % 2;
      m_acc = m_load && (g >= 0);
      chk("rnd_ready", r2, m_acc ? (2'b01 << g) : 2'b00);
      chk("rnd_en", en2, m_ov && !st2);
      if (m_ov && !st2) begin
        chk("rnd_reg", reg2, m_op.dst);
        chk("rnd_data", data2, m_op.data);
        chk("rnd_src", src2, m_src);
      end
      for (int i = 0; i < 2; i++) keep[i] = v2[i] && !(m_acc && g == i);
      if (m_acc) begin
        m_op = wb2[g]; m_src = 1'(g); m_ov = 1'b1; m_last = g;
      end else if (!st2) m_ov = 1'b0;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
